// File: rtl/gray_pkg.sv
// Shared mode encoding and width-agnostic Gray conversion helpers for the Gray codec pipeline.
// Callers zero-extend to MAX_WIDTH and truncate the result back to their own width.
package gray_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    MODE_B2G  = 2'b00,
    MODE_G2B  = 2'b01,
    MODE_PASS = 2'b10,
    MODE_CNT  = 2'b11
  } mode_t;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits leave the prefix XOR of the low bits unchanged.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One valid/ready register slice; loads when empty or when downstream drains it this cycle.
module gray_pipe_stage #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  assign up_ready = !dn_valid || dn_ready;

  // Data only moves together with a valid beat, so a stalled word stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= up_data;
      end
    end
  end

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray codec: per-beat bin->gray, gray->bin, pass-through or Gray counter,
// converted at entry and carried with its mode through STAGES valid/ready slices.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             cnt_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int SW = WIDTH + 2;

  mode_t            mode;
  logic             accept;
  logic             cnt_beat;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_sel;
  logic [WIDTH-1:0] entry_data;

  assign mode     = mode_t'(in_mode);
  assign in_ready = rst_n && g_stage[0].up_ready;
  assign accept   = in_valid && in_ready;
  assign cnt_beat = accept && (mode == MODE_CNT);
  assign cnt_sel  = cnt_clr ? {WIDTH{1'b0}} : cnt;

  always_comb begin
    entry_data = in_data;
    case (mode)
      MODE_B2G:  entry_data = WIDTH'(bin2gray(MAX_WIDTH'(in_data)));
      MODE_G2B:  entry_data = WIDTH'(gray2bin(MAX_WIDTH'(in_data)));
      MODE_PASS: entry_data = in_data;
      MODE_CNT:  entry_data = WIDTH'(bin2gray(MAX_WIDTH'(cnt_sel)));
      default:   entry_data = in_data;
    endcase
  end

  // A clear that lands on a count beat emits gray(0), so the next count is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= cnt_beat ? WIDTH'(1) : '0;
    end else if (cnt_beat) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic          up_valid;
    logic          up_ready;
    logic [SW-1:0] up_data;
    logic          dn_valid;
    logic          dn_ready;
    logic [SW-1:0] dn_data;

    if (s == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = {in_mode, entry_data};
    end else begin : g_next
      assign up_valid = g_stage[s-1].dn_valid;
      assign up_data  = g_stage[s-1].dn_data;
    end

    if (s == STAGES - 1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = g_stage[s+1].up_ready;
    end

    gray_pipe_stage #(.W(SW)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .up_data  (up_data),
      .dn_valid (dn_valid),
      .dn_ready (dn_ready),
      .dn_data  (dn_data)
    );
  end

  assign out_valid = g_stage[STAGES-1].dn_valid;
  assign out_data  = g_stage[STAGES-1].dn_data[WIDTH-1:0];
  assign out_mode  = g_stage[STAGES-1].dn_data[SW-1:WIDTH];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: arithmetic reference model with a FIFO scoreboard,
// plus literal expectations from hand-worked Gray tables.
module tb_gray_codec_pipe;

  localparam int WIDTH  = 4;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_mode = '0;
  logic             cnt_clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_mode;

  always #5 clk = ~clk;

  gray_codec_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .cnt_clr   (cnt_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [1:0]       mode;
    int               cyc;
  } beat_t;

  beat_t            exp_q[$];
  logic [WIDTH-1:0] out_log[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               cnt_m = 0;
  bit               stalled = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [1:0]       prev_mode = '0;

  function automatic logic [WIDTH-1:0] m_gray(input int v);
    return WIDTH'((v ^ (v >> 1)) & ((1 << WIDTH) - 1));
  endfunction

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [WIDTH-1:0] m_bin(input int g);
    int b = 0;
    for (int k = 0; k < WIDTH; k++) b = b ^ (g >> k);
    return WIDTH'(b & ((1 << WIDTH) - 1));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic modelAccept(input logic [WIDTH-1:0] d, input logic [1:0] m, input logic clr);
    beat_t b;
    b.mode = m;
    b.cyc  = cyc;
    b.data = d;
    case (m)
      2'b00: b.data = m_gray(int'(d));
      2'b01: b.data = m_bin(int'(d));
      2'b10: b.data = d;
      default: begin
        b.data = m_gray(clr ? 0 : cnt_m);
        cnt_m  = clr ? 1 : (cnt_m + 1) % (1 << WIDTH);
      end
    endcase
    if (m != 2'b11 && clr) cnt_m = 0;
    exp_q.push_back(b);
  endtask

  // Single compare process: inputs move at posedge+1, so negedge sees settled handshakes.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      cnt_m   = 0;
      stalled = 1'b0;
    end else begin
      cyc++;
      if (stalled) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_data", out_data, prev_data);
        checkOutput("stall_mode", out_mode, prev_mode);
      end
      if (out_valid && out_ready) begin
        out_log.push_back(out_data);
        if (exp_q.size() == 0) begin
          checkOutput("emit_unexpected", out_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_mode", out_mode, e.mode);
          checkOutput("latency_min", (cyc - e.cyc) >= STAGES, 1);
        end
      end
      if (in_valid && in_ready) modelAccept(in_data, in_mode, cnt_clr);
      else if (cnt_clr) cnt_m = 0;
      stalled   = out_valid && !out_ready;
      prev_data = out_data;
      prev_mode = out_mode;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] m,
                               input logic clr);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
    cnt_clr  = clr;
  endtask

  task automatic sendBeat(input logic [WIDTH-1:0] d, input logic [1:0] m, input logic clr);
    applyStimulus(1'b1, d, m, clr);
    step();
    applyStimulus(1'b0, '0, 2'b00, 1'b0);
  endtask

  task automatic drain();
    applyStimulus(1'b0, '0, 2'b00, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    step();
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  logic [WIDTH-1:0] cnt_seq [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                      4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                      4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] first;
    logic [1:0]       m;

    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_mode", out_mode, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", in_ready, 1);
    step();

    // Exact latency with no stall: 1011 -> 1110 two cycles after the accept cycle.
    applyStimulus(1'b1, 4'b1011, 2'b00, 1'b0);
    step();
    applyStimulus(1'b0, '0, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("lat_not_early", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat_exact_valid", out_valid, 1);
    checkOutput("b2g_1011", out_data, 4'b1110);
    step();
    drain();

    out_log.delete();
    sendBeat(4'b1101, 2'b00, 1'b0);
    sendBeat(4'b1110, 2'b01, 1'b0);
    drain();
    checkOutput("b2g_1101", out_log[0], 4'b1011);
    checkOutput("g2b_1110", out_log[1], 4'b1011);

    out_log.delete();
    for (int i = 0; i < 17; i++) sendBeat(4'($urandom_range(0, 15)), 2'b11, 1'b0);
    drain();
    checkOutput("count_len", out_log.size(), 17);
    for (int i = 0; i < 17; i++) checkOutput($sformatf("count_%0d", i), out_log[i], cnt_seq[i]);

    // Counter is at 1 here; clear on the 5th beat restarts the sequence.
    out_log.delete();
    for (int i = 0; i < 6; i++) sendBeat(4'hA, 2'b11, i == 4);
    drain();
    checkOutput("clr_beat5", out_log[4], 4'b0000);
    checkOutput("clr_beat6", out_log[5], 4'b0001);

    out_log.delete();
    for (int v = 0; v < 16; v++) begin
      m     = 2'($urandom_range(0, 1));
      first = (m == 2'b00) ? m_gray(v) : m_bin(v);
      sendBeat(4'(v), m, 1'b0);
      sendBeat(first, 2'b01 - m, 1'b0);
    end
    drain();
    for (int v = 0; v < 16; v++) checkOutput($sformatf("round_trip_%0d", v), out_log[2*v+1], v);

    out_ready = 1'b0;
    applyStimulus(1'b1, 4'h3, 2'b10, 1'b0);
    step();
    step();
    @(negedge clk);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_out_valid", out_valid, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    #1 checkOutput("ready_follows_out", in_ready, 1);
    step();
    drain();

    for (int i = 0; i < 500; i++) begin
      out_ready = ($urandom_range(0, 99) < 30);
      applyStimulus(1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 15) == 0);
      step();
    end
    drain();

    // Reset with two beats in flight and a non-zero counter.
    sendBeat('0, 2'b11, 1'b0);
    sendBeat('0, 2'b11, 1'b0);
    drain();
    out_ready = 1'b0;
    sendBeat(4'h5, 2'b10, 1'b0);
    sendBeat(4'h6, 2'b11, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_no_ghost", out_valid, 0);
    step();
    out_ready = 1'b1;
    out_log.delete();
    sendBeat(4'hF, 2'b11, 1'b0);
    drain();
    checkOutput("rst_count_len", out_log.size(), 1);
    checkOutput("rst_count_zero", out_log[0], 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
